pfb_tap_accumulator: RTL and testbench
======================================

Name: pfb_tap_accumulator

Overview:
- Downstream of the coefficient × sample multiplier stage in the PFB block decimator.
- Consumes the unsigned 23-bit products and sums NUM_TAPS products per channel.
- Emits one decimated sum per channel per frame to the FFT stage.
- Products arrive tap-major: tap 0 for channels 0..NUM_CH-1, then tap 1 for the same channels, and so on.

Parameters:
- DIN_WIDTH, 23, unsigned product width from the multiplier.
- NUM_CH, 16, channels per tap group; power of two, ≥2.
- NUM_TAPS, 8, taps per channel; power of two, ≥2.
- ACC_WIDTH, DIN_WIDTH+log2(NUM_TAPS) (derived localparam, 26 at defaults), output and accumulator width.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- s_tdata  in  DIN_WIDTH  unsigned product.
- s_tvalid  in  1  product valid.
- s_tuser  in  1  frame-start marker; asserted with tap 0, channel 0.
- s_tready  out  1  stage can accept.
- m_tdata  out  ACC_WIDTH  channel sum.
- m_tvalid  out  1  sum valid.
- m_tlast  out  1  set on the sum for channel NUM_CH-1.
- m_tready  in  1  downstream accept.
- sync_err  out  1  sticky; frame marker seen at an unexpected position.

Behaviour:
- Reset (ap_rst=1 at an edge):
  - ch_cnt=0, tap_cnt=0; m_tvalid=0, m_tdata=0, m_tlast=0, sync_err=0.
  - Accumulator contents are don't-care, because tap 0 overwrites them.
  - Reset mid-frame discards the partial sums. The next accepted sample is tap 0, channel 0.
- Handshake:
  - s_tready = !m_tvalid || m_tready (combinational).
  - A sample is accepted when s_tvalid && s_tready.
  - An output transfers when m_tvalid && m_tready.
  - m_tdata and m_tlast hold stable while m_tvalid && !m_tready.
- Counters, advanced only on accept:
  - ch_cnt increments and wraps from NUM_CH-1 to 0.
  - On that wrap, tap_cnt increments and wraps from NUM_TAPS-1 to 0.
- Accumulate, per accepted sample with c=ch_cnt:
  - tap_cnt==0: acc[c] <= zero-extend(s_tdata).
  - 0<tap_cnt<NUM_TAPS-1: acc[c] <= acc[c] + s_tdata.
  - tap_cnt==NUM_TAPS-1: m_tdata <= acc[c] + s_tdata; m_tvalid <= 1; m_tlast <= (c==NUM_CH-1). acc[c] is not written.
- Output behaviour:
  - Latency: 1 cycle from accepting the last tap to m_tvalid.
  - m_tvalid clears on transfer unless a new result loads in the same cycle.
  - Back-to-back results sustain one per cycle with m_tready held high.
- Width:
  - Unsigned arithmetic throughout.
  - ACC_WIDTH guarantees no overflow: max 8×(2^23−1) < 2^26.
- Frame marker:
  - Accepted s_tuser=1 while (ch_cnt,tap_cnt)≠(0,0):
    - set sync_err;
    - treat the sample as tap 0, channel 0 (acc[0] loaded);
    - counters become ch=1, tap=0;
    - no output is produced for the aborted frame.
  - s_tuser=1 at (0,0) is normal.
  - s_tuser=0 at (0,0) is accepted silently.
  - sync_err clears only on ap_rst.
- Simultaneous events:
  - Output transfer and a new last-tap load in the same cycle: the new result loads and m_tvalid stays 1.
  - s_tvalid with ap_rst: reset wins and the sample is dropped.

Decomposition:
- Shared package pfb_decim_pkg:
  - DIN_WIDTH, NUM_CH, NUM_TAPS;
  - derived CH_BITS, TAP_BITS, ACC_WIDTH;
  - the count-type typedefs.
- Sub-module pfb_acc_ram: NUM_CH × ACC_WIDTH storage, one async read and one sync write port, at address ch_cnt.
- Counters, output register and handshake live in the top.

Test Plan (all at defaults unless stated):
- Ramp: 128 samples, s_tdata = tap+1 for every channel, m_tready=1 → 16 outputs, each 36, m_tlast only on the 16th, first m_tvalid one cycle after sample 113 is accepted.
- Max values: all s_tdata=0x7FFFFF → every m_tdata=0x3FFFFF8 (8×8388607), no wrap.
- Backpressure: hold m_tready=0 during the last-tap group → s_tready drops after the first result. m_tdata stays at channel 0's sum until released. All 16 sums are delivered in order, none lost.
- Resync: s_tuser=1 on sample 40 (mid-frame), then a clean 128-sample frame of 1s → sync_err=1. Exactly 16 outputs follow, each 8.
- Reset mid-frame: ap_rst pulsed after 70 samples, then a 128-sample frame of value 2 → m_tvalid=0 during reset. Then 16 outputs of 16, sync_err=0.
- Gapped input: s_tvalid toggling 50% random, m_tready random → outputs identical to the ramp case and ordered, with m_tdata stable while stalled.

Source files
------------

// File: rtl/pfb_decim_pkg.sv
// Shared sizing and count types for the PFB decimator tap accumulation path.
package pfb_decim_pkg;

  localparam int unsigned DIN_WIDTH = 23;
  localparam int unsigned NUM_CH    = 16;
  localparam int unsigned NUM_TAPS  = 8;

  localparam int unsigned CH_BITS   = $clog2(NUM_CH);
  localparam int unsigned TAP_BITS  = $clog2(NUM_TAPS);
  localparam int unsigned ACC_WIDTH = DIN_WIDTH + TAP_BITS;

  typedef logic [CH_BITS-1:0]   ch_cnt_t;
  typedef logic [TAP_BITS-1:0]  tap_cnt_t;
  typedef logic [DIN_WIDTH-1:0] din_t;
  typedef logic [ACC_WIDTH-1:0] acc_t;

endpackage

// File: rtl/pfb_acc_ram.sv
// Per-channel partial-sum storage: asynchronous read, synchronous write, single shared address.
module pfb_acc_ram
  import pfb_decim_pkg::*;
(
  input  logic    clk,
  input  logic    we,
  input  ch_cnt_t addr,
  input  acc_t    wdata,
  output acc_t    rdata
);

  acc_t mem_q [NUM_CH];

  // No reset: every partial sum is overwritten by tap 0 before it is read.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/pfb_tap_accumulator.sv
// Sums NUM_TAPS tap-major products per channel and emits one decimated sum per channel per frame.
module pfb_tap_accumulator
  import pfb_decim_pkg::*;
(
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic [DIN_WIDTH-1:0] s_tdata,
  input  logic                 s_tvalid,
  input  logic                 s_tuser,
  output logic                 s_tready,
  output logic [ACC_WIDTH-1:0] m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  input  logic                 m_tready,
  output logic                 sync_err
);

  ch_cnt_t  ch_q, ch_d;
  tap_cnt_t tap_q, tap_d;
  acc_t     m_tdata_q, m_tdata_d;
  logic     m_tvalid_q, m_tvalid_d;
  logic     m_tlast_q, m_tlast_d;
  logic     sync_err_q, sync_err_d;

  logic     accept;
  logic     resync;
  logic     first_tap;
  logic     last_tap;
  ch_cnt_t  ram_addr;
  acc_t     ram_rdata;
  acc_t     ram_wdata;
  acc_t     din_ext;
  acc_t     sum;
  logic     ram_we;

  assign s_tready = !m_tvalid_q || m_tready;

  always_comb begin
    accept    = s_tvalid && s_tready;
    resync    = accept && s_tuser && ((ch_q != '0) || (tap_q != '0));
    first_tap = resync || (tap_q == '0);
    last_tap  = !resync && (tap_q == TAP_BITS'(NUM_TAPS - 1));
    // A misplaced frame marker restarts the frame at channel 0.
    ram_addr  = resync ? '0 : ch_q;
    din_ext   = ACC_WIDTH'(s_tdata);
    sum       = ram_rdata + din_ext;
    ram_wdata = first_tap ? din_ext : sum;
    ram_we    = accept && !ap_rst && !last_tap;
  end

  pfb_acc_ram u_acc_ram (
    .clk   (ap_clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Counter, output register and sticky error next-state.
  always_comb begin
    ch_d       = ch_q;
    tap_d      = tap_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    m_tvalid_d = m_tvalid_q && !m_tready;
    sync_err_d = sync_err_q || resync;

    if (resync) begin
      ch_d  = CH_BITS'(1);
      tap_d = '0;
    end else if (accept) begin
      ch_d = ch_q + CH_BITS'(1);
      if (ch_q == CH_BITS'(NUM_CH - 1)) tap_d = tap_q + TAP_BITS'(1);
    end

    if (accept && last_tap) begin
      m_tdata_d  = sum;
      m_tvalid_d = 1'b1;
      m_tlast_d  = (ch_q == CH_BITS'(NUM_CH - 1));
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ch_q       <= '0;
      tap_q      <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      ch_q       <= ch_d;
      tap_q      <= tap_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_pfb_tap_accumulator.sv
// Scoreboard bench for pfb_tap_accumulator: directed frames push expected sums, a monitor pops on transfer.
module tb_pfb_tap_accumulator;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [22:0] s_tdata;
  logic        s_tvalid;
  logic        s_tuser;
  logic        s_tready;
  logic [25:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic        sync_err;

  typedef struct packed {
    logic [25:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   hold_until = 0;
  bit   rand_rdy = 1'b0;

  pfb_tap_accumulator dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tuser  (s_tuser),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .sync_err (sync_err)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
    end
  endtask

  // Downstream ready: held low during a backpressure window, optionally random otherwise.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge ap_clk);
      #1;
      if (cyc < hold_until) m_tready = 1'b0;
      else if (rand_rdy)    m_tready = 1'($urandom_range(0, 1));
      else                  m_tready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks stalled outputs hold.
  logic        stall_prev = 1'b0;
  logic [25:0] prev_data;
  logic        prev_last;
  initial begin
    exp_t e;
    forever begin
      @(negedge ap_clk);
      if (ap_rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", 64'(m_tvalid), 64'd1);
          check("stall_data", 64'(m_tdata), 64'(prev_data));
          check("stall_last", 64'(m_tlast), 64'(prev_last));
        end
        stall_prev = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(m_tdata), 64'h0);
            check("unexpected_output_count", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 64'(m_tdata), 64'(e.data));
            check("out_last", 64'(m_tlast), 64'(e.last));
          end
        end
      end
    end
  end

  task automatic send(input logic [22:0] d, input logic u, input bit gap);
    int  n;
    bit  rdy;
    if (gap) begin
      while ($urandom_range(0, 1) == 1) begin
        @(posedge ap_clk);
        #1;
      end
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tuser  = u;
    n = 0;
    do begin
      @(negedge ap_clk);
      rdy = s_tready;
      @(posedge ap_clk);
      #1;
      n++;
    end while (!rdy && n < 1000);
    if (!rdy) check("send_timeout", 64'd0, 64'd1);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
  endtask

  // One full frame; pushes the 16 hand-computed sums before any sample goes out.
  task automatic send_frame(input bit ramp, input logic [22:0] val, input logic [25:0] exp_sum,
                            input bit user0, input bit gap, input bit chk_lat, input bit bp);
    exp_t e;
    for (int c = 0; c < 16; c++) begin
      e.data = exp_sum;
      e.last = (c == 15);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 128; i++) begin
      if (bp && i == 112) hold_until = cyc + 30;
      send(ramp ? 23'(i / 16 + 1) : val, (i == 0) ? user0 : 1'b0, gap);
      if (chk_lat && i == 111) check("latency_before_last_tap", 64'(m_tvalid), 64'd0);
      if (chk_lat && i == 112) check("latency_first_valid", 64'(m_tvalid), 64'd1);
      if (bp && i == 112) begin
        @(negedge ap_clk);
        check("bp_valid", 64'(m_tvalid), 64'd1);
        check("bp_s_tready_low", 64'(s_tready), 64'd0);
        check("bp_hold_ch0", 64'(m_tdata), 64'd24);
        @(posedge ap_clk);
        #1;
      end
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge ap_clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge ap_clk);
    #1;
  endtask

  initial begin
    ap_rst   = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_tdata), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_sync_err", 64'(sync_err), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd1);
    @(posedge ap_clk);
    #1;

    // Ramp: tap+1 on every channel sums to 36.
    send_frame(1'b1, 23'd0, 26'd36, 1'b1, 1'b0, 1'b1, 1'b0);
    drain("ramp_drain");

    // Full-scale products must not wrap.
    send_frame(1'b0, 23'h7FFFFF, 26'h3FFFFF8, 1'b1, 1'b0, 1'b0, 1'b0);
    drain("max_drain");
    check("max_no_sync_err", 64'(sync_err), 64'd0);

    // Backpressure during the last-tap group: 8 x 3 = 24.
    send_frame(1'b0, 23'd3, 26'd24, 1'b1, 1'b0, 1'b0, 1'b1);
    drain("bp_drain");

    // Resync: 39 samples, then sample 40 carries the marker and opens a clean frame of 1s.
    for (int i = 0; i < 39; i++) send(23'd1, (i == 0), 1'b0);
    check("pre_resync_sync_err", 64'(sync_err), 64'd0);
    send_frame(1'b0, 23'd1, 26'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    check("resync_sync_err", 64'(sync_err), 64'd1);
    drain("resync_drain");

    // Reset mid-frame with a sample offered during reset.
    for (int i = 0; i < 70; i++) send(23'd2, (i == 0), 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 23'd5;
    ap_rst   = 1'b1;
    @(posedge ap_clk);
    #1;
    @(negedge ap_clk);
    check("rst_mid_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_mid_sync_err", 64'(sync_err), 64'd0);
    @(posedge ap_clk);
    #1;
    ap_rst   = 1'b0;
    s_tvalid = 1'b0;
    send_frame(1'b0, 23'd2, 26'd16, 1'b1, 1'b0, 1'b0, 1'b0);
    drain("rst_frame_drain");
    check("post_rst_sync_err", 64'(sync_err), 64'd0);

    // Gapped input with random downstream ready reproduces the ramp.
    rand_rdy = 1'b1;
    send_frame(1'b1, 23'd0, 26'd36, 1'b1, 1'b1, 1'b0, 1'b0);
    drain("gapped_drain");
    rand_rdy = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("final_sync_err", 64'(sync_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
